// File: rtl/mini_src_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM encoding, step count
// and the recoding of the {Q[0], q_1} bit pair.
package mini_src_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         MUL_STEPS = 32;
  localparam logic [5:0] LAST_STEP = 6'(MUL_STEPS - 1);

  // Returns {add, sub}: pair 01 adds M, pair 10 subtracts M, 00/11 leave A alone.
  function automatic logic [1:0] booth_sel(input logic q0, input logic q_1);
    return {~q0 & q_1, q0 & ~q_1};
  endfunction

endpackage

// File: rtl/rca32.sv
// 32-bit ripple-carry adder built from explicit full-adder cells.
module rca32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [32:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[32];

endmodule

// File: rtl/booth_mul32.sv
// Sequential radix-2 Booth multiplier: 32x32 signed -> 64-bit product in 32 RUN cycles.
// The shared rca32 performs A+M or A+~M+1; A/Q form the HI/LO product registers.
module booth_mul32
  import mini_src_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] q_q, q_d;
  logic        q1_q, q1_d;
  logic [31:0] m_q, m_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [1:0]  sel;
  logic        add_en, sub_en;
  logic [31:0] rca_b, rca_sum;
  logic        rca_cout;
  logic        sum_sign;
  logic [31:0] acc;
  logic        acc_msb;

  assign sel    = booth_sel(q_q[0], q1_q);
  assign add_en = sel[1];
  assign sub_en = sel[0];
  assign rca_b  = sub_en ? ~m_q : m_q;

  rca32 u_rca (
    .a_i   (a_q),
    .b_i   (rca_b),
    .cin_i (sub_en),
    .sum_o (rca_sum),
    .cout_o(rca_cout)
  );

  // Bit 32 of the sign-extended sum, so the shifted-in sign survives overflow (e.g. M = 0x80000000).
  assign sum_sign = a_q[31] ^ rca_b[31] ^ rca_cout;
  assign acc      = (add_en | sub_en) ? rca_sum : a_q;
  assign acc_msb  = (add_en | sub_en) ? sum_sign : a_q[31];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = '0;
          q_d     = multiplier;
          q1_d    = 1'b0;
          m_d     = multiplicand;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = {acc_msb, acc[31:1]};
        q_d   = {acc[0], q_q[31:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign product_hi = a_q;
  assign product_lo = q_q;

endmodule

// File: doc/booth_mul32.md
BOOTH_MUL32 -- requirements
Module: booth_mul32

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; only 32 is legal because the 32-bit ripple adder is fixed-width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clock  input  1  rising-edge system clock.
REQ-004 Port: reset_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request a multiply; sampled on a rising clock edge.
REQ-006 Port: multiplicand  input  32  signed operand M; sampled with start.
REQ-007 Port: multiplier  input  32  signed operand Q; sampled with start.
REQ-008 Port: busy  output  1  high while the multiply is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when the product is valid.
REQ-010 Port: product_hi  output  32  upper half of the signed 64-bit product (HI register source).
REQ-011 Port: product_lo  output  32  lower half of the signed 64-bit product (LO register source).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE -> RUN when start=1.
REQ-014 RUN -> DONE after the 32nd step.
REQ-015 DONE -> IDLE unconditionally after one cycle.
REQ-016 start SHALL be honoured only in IDLE.
REQ-017 start in RUN or DONE SHALL be ignored, and the in-flight operands and result SHALL be unaffected.
REQ-018 On accept, the block SHALL load A=0, Q=multiplier, q_1=0, M=multiplicand, step counter=0.
REQ-019 In each RUN cycle, the block SHALL examine {Q[0], q_1}:
- 01 -> A+M;
- 10 -> A-M, formed as A + ~M with Cin=1;
- 00 or 11 -> A unchanged.
It SHALL then arithmetic-shift {A, Q, q_1} right by one.
REQ-020 The bit shifted into A[31] SHALL be the true sign of the 33-bit result, i.e. Sum[31] XOR signed-overflow, so that M = 0x80000000 is correct.
REQ-021 The step counter SHALL be 6 bits and increment once per RUN cycle; the 32nd step SHALL occur when the counter = 31.
REQ-022 Latency: start accepted at edge T -> busy=1 from T through T+32 -> done=1 for exactly the cycle following edge T+32.
REQ-023 busy=0 in IDLE and DONE.
REQ-024 {product_hi, product_lo} SHALL equal {A, Q} and be valid while done=1.
REQ-025 product_hi and product_lo SHALL hold their value until the next accepted start; they MAY change during RUN.
REQ-026 The product SHALL be the exact two's-complement product for all 2^64 operand pairs; no overflow is possible.
REQ-027 Back-to-back operations: start held high SHALL be re-accepted in the IDLE cycle after DONE, giving a period of 34 cycles.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, product_hi=0, product_lo=0, counter=0, q_1=0 and M=0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-030 After reset release, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-031 The FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and MUL_STEPS=32 SHALL live in the shared package mini_src_pkg.
REQ-032 The add/subtract path SHALL use exactly one instance of the existing rca32 sub-module.
REQ-033 The operand B of rca32 SHALL be M or ~M, and Cin SHALL equal the subtract select.
REQ-034 There SHALL be no behavioural '*' or '+' on the 32-bit datapath; only the 6-bit counter MAY use '+'.

Verification
REQ-035 multiplicand=3, multiplier=5, start one cycle -> done exactly 33 cycles after the accepting edge; product_hi=0x00000000, product_lo=0x0000000F.
REQ-036 0xFFFFFFFF x 0xFFFFFFFF (-1 x -1) -> product_hi=0x00000000, product_lo=0x00000001.
REQ-037 0x80000000 x 0x80000000 -> product_hi=0x40000000, product_lo=0x00000000; and 0x7FFFFFFF x 0x80000000 -> product_hi=0xC0000000, product_lo=0x80000000.
REQ-038 Start 7 x -6 (0xFFFFFFFA), then pulse start=1 with 2 x 2 at cycle 10 of RUN -> result 0xFFFFFFFF_FFFFFFD6, single done pulse, second request ignored.
REQ-039 reset_n=0 at RUN step 15 -> busy/done/product all 0 immediately and no done pulse; then 9 x 9 -> product_lo=0x00000051.
REQ-040 Randomised self-check: 10,000 signed operand pairs against a 64-bit reference model, with start held high -> every result matches and the period is exactly 34 cycles.
